// File: rtl/gpio_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// gpio_multi : NUM_PORTS x PORT_WIDTH GPIO controller behind one bus slave.
// Optional input debouncing when GPIO_DEBOUNCE_EN is defined.  Rev 1.0
// ============================================================================
module gpio_multi #(
   parameter int NUM_PORTS       = 3,
   parameter int PORT_WIDTH      = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             sel_i,
   input  logic                             req_i,
   input  logic                             we_i,
   input  logic [7:0]                       addr_i,
   input  logic [31:0]                      wdata_i,
   output logic [31:0]                      rdata_o,
   output logic                             ack_o,
   output logic                             irq_o,
   input  logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_i,
   output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_o,
   output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_oe_o
);

   localparam int C_TOTAL = NUM_PORTS * PORT_WIDTH;

   localparam logic [2:0] C_REG_DIR    = 3'd0;
   localparam logic [2:0] C_REG_DOUT   = 3'd1;
   localparam logic [2:0] C_REG_DIN    = 3'd2;
   localparam logic [2:0] C_REG_IEN    = 3'd3;
   localparam logic [2:0] C_REG_IRISE  = 3'd4;
   localparam logic [2:0] C_REG_IFALL  = 3'd5;
   localparam logic [2:0] C_REG_STATUS = 3'd6;

   logic                  w_accept;
   logic                  w_wr;
   logic [2:0]            w_port;
   logic [2:0]            w_reg;
   logic                  w_unused;

   logic [C_TOTAL-1:0]    r_sync [SYNC_STAGES];
   logic [C_TOTAL-1:0]    w_sync_out;
   logic [C_TOTAL-1:0]    w_in_val;
   logic [C_TOTAL-1:0]    r_hist;
   logic [C_TOTAL-1:0]    w_rise;
   logic [C_TOTAL-1:0]    w_fall;

   logic [C_TOTAL-1:0]    w_dir_all;
   logic [C_TOTAL-1:0]    w_dout_all;
   logic [C_TOTAL-1:0]    w_ien_all;
   logic [C_TOTAL-1:0]    w_irise_all;
   logic [C_TOTAL-1:0]    w_ifall_all;
   logic [C_TOTAL-1:0]    w_stat_all;

   logic [PORT_WIDTH-1:0] w_rd_val;
   logic [31:0]           w_rd32;

   assign w_accept = sel_i & req_i;
   assign w_wr     = w_accept & we_i;
   assign w_port   = addr_i[7:5];
   assign w_reg    = addr_i[4:2];
   assign w_unused = ^{addr_i[1:0], wdata_i};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_hist <= '0;
      end else begin
         r_sync[0] <= gpio_i;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_hist <= w_in_val;
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

   // Counter tracks consecutive cycles the synchroniser disagrees with the filtered value.
   for (genvar i = 0; i < C_TOTAL; i++) begin : g_deb
      logic [C_CNT_W-1:0] r_cnt;
      logic               r_deb;
      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
         end else if (w_sync_out[i] == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == C_CNT_LAST) begin
            r_cnt <= '0;
            r_deb <= w_sync_out[i];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
      assign w_in_val[i] = r_deb;
   end
`else
   assign w_in_val = w_sync_out;
`endif

   assign w_rise = w_in_val & ~r_hist;
   assign w_fall = ~w_in_val & r_hist;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic                  w_hit;
      logic [PORT_WIDTH-1:0] w_set;
      logic [PORT_WIDTH-1:0] w_clr;
      logic [PORT_WIDTH-1:0] r_dir, r_dout, r_ien, r_irise, r_ifall, r_stat;

      assign w_hit = w_wr && (w_port == 3'(p));
      assign w_set = (w_rise[p*PORT_WIDTH +: PORT_WIDTH] & r_irise)
                   | (w_fall[p*PORT_WIDTH +: PORT_WIDTH] & r_ifall);
      assign w_clr = (w_hit && w_reg == C_REG_STATUS) ? wdata_i[PORT_WIDTH-1:0] : '0;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_dir   <= '0;
            r_dout  <= '0;
            r_ien   <= '0;
            r_irise <= '0;
            r_ifall <= '0;
            r_stat  <= '0;
         end else begin
            if (w_hit) begin
               case (w_reg)
                  C_REG_DIR:   r_dir   <= wdata_i[PORT_WIDTH-1:0];
                  C_REG_DOUT:  r_dout  <= wdata_i[PORT_WIDTH-1:0];
                  C_REG_IEN:   r_ien   <= wdata_i[PORT_WIDTH-1:0];
                  C_REG_IRISE: r_irise <= wdata_i[PORT_WIDTH-1:0];
                  C_REG_IFALL: r_ifall <= wdata_i[PORT_WIDTH-1:0];
                  default: ;
               endcase
            end
            // Set is OR-ed after the clear so a coincident edge wins.
            r_stat <= (r_stat & ~w_clr) | w_set;
         end
      end

      assign w_dir_all  [p*PORT_WIDTH +: PORT_WIDTH] = r_dir;
      assign w_dout_all [p*PORT_WIDTH +: PORT_WIDTH] = r_dout;
      assign w_ien_all  [p*PORT_WIDTH +: PORT_WIDTH] = r_ien;
      assign w_irise_all[p*PORT_WIDTH +: PORT_WIDTH] = r_irise;
      assign w_ifall_all[p*PORT_WIDTH +: PORT_WIDTH] = r_ifall;
      assign w_stat_all [p*PORT_WIDTH +: PORT_WIDTH] = r_stat;
   end

   // Ports beyond NUM_PORTS never match and therefore read as zero.
   always_comb begin
      w_rd_val = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_port == 3'(p)) begin
            case (w_reg)
               C_REG_DIR:    w_rd_val = w_dir_all  [p*PORT_WIDTH +: PORT_WIDTH];
               C_REG_DOUT:   w_rd_val = w_dout_all [p*PORT_WIDTH +: PORT_WIDTH];
               C_REG_DIN:    w_rd_val = w_in_val   [p*PORT_WIDTH +: PORT_WIDTH];
               C_REG_IEN:    w_rd_val = w_ien_all  [p*PORT_WIDTH +: PORT_WIDTH];
               C_REG_IRISE:  w_rd_val = w_irise_all[p*PORT_WIDTH +: PORT_WIDTH];
               C_REG_IFALL:  w_rd_val = w_ifall_all[p*PORT_WIDTH +: PORT_WIDTH];
               C_REG_STATUS: w_rd_val = w_stat_all [p*PORT_WIDTH +: PORT_WIDTH];
               default:      w_rd_val = '0;
            endcase
         end
      end
      w_rd32                   = '0;
      w_rd32[PORT_WIDTH-1:0]   = w_rd_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_o   <= 1'b0;
         rdata_o <= '0;
         irq_o   <= 1'b0;
      end else begin
         ack_o   <= w_accept;
         rdata_o <= (w_accept && !we_i) ? w_rd32 : 32'h0;
         irq_o   <= |(w_stat_all & w_ien_all);
      end
   end

   assign gpio_o    = w_dout_all;
   assign gpio_oe_o = w_dir_all;

endmodule
`default_nettype wire

// File: tb/tb_gpio_multi.sv
`default_nettype none
`timescale 1ns/1ps
// tb_gpio_multi : scoreboard bench for gpio_multi with directed vectors.
module tb_gpio_multi;

   localparam int NP = 3;
   localparam int PW = 8;
   localparam int SS = 2;
`ifdef GPIO_DEBOUNCE_EN
   localparam int DEB = 4;
   localparam int LAT = SS + DEB;
`else
   localparam int DEB = 16;
   localparam int LAT = SS;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sel = 1'b0;
   logic          req = 1'b0;
   logic          we  = 1'b0;
   logic [7:0]    addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata_o;
   logic          ack_o;
   logic          irq_o;
   logic [NP*PW-1:0] gpio_i = '0;
   logic [NP*PW-1:0] gpio_o;
   logic [NP*PW-1:0] gpio_oe_o;

   gpio_multi #(
      .NUM_PORTS(NP), .PORT_WIDTH(PW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .rst(rst), .sel_i(sel), .req_i(req), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_o), .ack_o(ack_o),
      .irq_o(irq_o), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t q[$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
      end
   endtask

   task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] e, input string nm);
      exp_t x;
      @(negedge clk);
      sel = 1'b1; req = 1'b1; we = w; addr = a; wdata = d;
      x.name = nm; x.data = w ? 32'h0 : e; x.cyc = cyc;
      q.push_back(x);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
      bus(1'b1, a, d, 32'h0, nm);
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
      bus(1'b0, a, 32'h0, e, nm);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sel = 1'b0; req = 1'b0; we = 1'b0;
      end
   endtask

   // Monitor: every ack pops one expectation; a missing ack is also reported.
   always @(negedge clk) begin
      exp_t e;
      if (ack_o) begin
         if (q.size() == 0) begin
            chk("spurious_ack", 32'(ack_o), 32'h0);
         end else begin
            e = q.pop_front();
            chk({e.name, "_lat"}, 32'(cyc), 32'(e.cyc + 1));
            chk(e.name, rdata_o, e.data);
         end
      end else if (q.size() > 0 && cyc >= q[0].cyc + 1) begin
         e = q.pop_front();
         chk({e.name, "_noack"}, 32'(ack_o), 32'h1);
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ack",  32'(ack_o), 32'h0);
      chk("rst_rd",   rdata_o, 32'h0);
      chk("rst_irq",  32'(irq_o), 32'h0);
      chk("rst_gpo",  32'(gpio_o), 32'h0);
      chk("rst_oe",   32'(gpio_oe_o), 32'h0);
      rst = 1'b0;

      for (int r = 0; r < 8; r++) rd(8'(r * 4), 32'h0, $sformatf("rst_reg%0d", r));
      gpio_i[1] = 1'b1;
      idle(LAT + 3);

      wr(8'h20, 32'h0000_00F0, "dir1");
      wr(8'h24, 32'hFFFF_FFA5, "dout1");
      chk("dout_before", 32'(gpio_o[15:8]), 32'h0);
      rd(8'h24, 32'h0000_00A5, "dout1_rb");
      chk("oe1",  32'(gpio_oe_o[15:8]), 32'h0000_00F0);
      chk("out1", 32'(gpio_o[15:8]),    32'h0000_00A5);
      wr(8'h3C, 32'hFF, "rsv_wr");
      rd(8'h3C, 32'h0, "rsv_rd");

      rd(8'h48, 32'h0, "din2_k0");
      gpio_i[23:16] = 8'h3C;
      for (int k = 1; k <= LAT; k++)
         rd(8'h48, (k < LAT) ? 32'h0 : 32'h3C, $sformatf("din2_k%0d", k));
      wr(8'h48, 32'hFF, "din_wr");
      rd(8'h48, 32'h3C, "din_ro");

      wr(8'h10, 32'h1, "irise0");
      wr(8'h14, 32'h2, "ifall0");
      wr(8'h0C, 32'h3, "ien0");
      idle(1);
      gpio_i[0] = 1'b1;
      idle(LAT + 2);
      chk("irq_rise", 32'(irq_o), 32'h1);
      rd(8'h18, 32'h1, "stat_rise");
      gpio_i[1] = 1'b0;
      idle(LAT + 2);
      rd(8'h18, 32'h3, "stat_fall");
      wr(8'h18, 32'h1, "w1c_b0");
      rd(8'h18, 32'h2, "stat_after_b0");
      idle(1);
      chk("irq_stay", 32'(irq_o), 32'h1);
      wr(8'h18, 32'h2, "w1c_b1");
      idle(1);
      chk("irq_lag", 32'(irq_o), 32'h1);
      idle(1);
      chk("irq_clr", 32'(irq_o), 32'h0);

      gpio_i[0] = 1'b0;
      idle(LAT + 2);
      rd(8'h18, 32'h0, "stat_pre");
      gpio_i[0] = 1'b1;
      idle(LAT - 1);
      wr(8'h18, 32'h1, "w1c_collide");
      rd(8'h18, 32'h1, "collide");
      wr(8'h18, 32'h1, "w1c_cleanup");

      wr(8'hE4, 32'hFF, "oor_wr");
      rd(8'hE0, 32'h0, "oor_rd");
      rd(8'h64, 32'h0, "oor_p3");

`ifdef GPIO_DEBOUNCE_EN
      wr(8'h30, 32'h1, "irise1");
      wr(8'h2C, 32'h1, "ien1");
      idle(1);
      gpio_i[8] = 1'b1;
      idle(3);
      gpio_i[8] = 1'b0;
      idle(12);
      rd(8'h28, 32'h0, "deb_glitch_din");
      rd(8'h38, 32'h0, "deb_glitch_stat");
      gpio_i[8] = 1'b1;
      idle(12);
      rd(8'h28, 32'h1, "deb_level_din");
      rd(8'h38, 32'h1, "deb_level_stat");
      wr(8'h38, 32'h1, "deb_w1c");
      wr(8'h2C, 32'h0, "deb_ien_off");
`endif

      idle(3);
      @(negedge clk);
      sel = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h24; rst = 1'b1;
      @(negedge clk);
      chk("midrst_ack", 32'(ack_o), 32'h0);
      chk("midrst_gpo", 32'(gpio_o), 32'h0);
      sel = 1'b0; req = 1'b0; rst = 1'b0;
      idle(3);
      chk("queue_empty", 32'(q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
